// File: rtl/uart_alu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_alu_pkg
// Brief    : Shared types and sizing helpers for the UART byte-channel arbiter.
// Revision : 1.0
// ============================================================================
package uart_alu_pkg;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

  // Watchdog counter must be able to hold TIMEOUT; never narrower than 1 bit.
  function automatic int cnt_width(input int timeout);
    int w;
    w = $clog2(timeout + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_arbiter_if
// Brief    : AXI-Stream bundle between byte sources, the arbiter and uart_tx.
// Revision : 1.0
// ============================================================================
interface uart_tx_arbiter_if #(
  parameter int NUM_SRC    = 2,
  parameter int DATA_WIDTH = 8
);

  logic [NUM_SRC*DATA_WIDTH-1:0] s_tdata;
  logic [NUM_SRC-1:0]            s_tvalid;
  logic [NUM_SRC-1:0]            s_tlast;
  logic [NUM_SRC-1:0]            s_tready;
  logic [DATA_WIDTH-1:0]         m_tdata;
  logic                          m_tvalid;
  logic                          m_tlast;
  logic                          m_tready;

  modport slave (
    input  s_tdata, s_tvalid, s_tlast, m_tready,
    output s_tready, m_tdata, m_tvalid, m_tlast
  );

  modport master (
    output s_tdata, s_tvalid, s_tlast, m_tready,
    input  s_tready, m_tdata, m_tvalid, m_tlast
  );

endinterface
`default_nettype wire

// File: rtl/rr_priority_pick.sv
`default_nettype none
// ============================================================================
// Module   : rr_priority_pick
// Brief    : Combinational round-robin pick: first requester from ptr upward.
// Revision : 1.0
// ============================================================================
module rr_priority_pick #(
  parameter int NUM_SRC = 2,
  parameter int PTR_W   = 1
) (
  input  wire logic [NUM_SRC-1:0] req,
  input  wire logic [PTR_W-1:0]   ptr,
  output logic      [NUM_SRC-1:0] grant,
  output logic                    any
);

  logic [PTR_W:0]   w_sum;
  logic [PTR_W-1:0] w_idx;
  logic             w_found;

  always_comb begin
    grant   = '0;
    w_found = 1'b0;
    w_sum   = '0;
    w_idx   = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      w_sum = {1'b0, ptr} + (PTR_W+1)'(k);
      if (w_sum >= (PTR_W+1)'(NUM_SRC)) begin
        w_sum = w_sum - (PTR_W+1)'(NUM_SRC);
      end
      w_idx = w_sum[PTR_W-1:0];
      if (req[w_idx] && !w_found) begin
        grant[w_idx] = 1'b1;
        w_found      = 1'b1;
      end
    end
  end

  assign any = |req;

endmodule
`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_arbiter
// Brief    : Packet-locked round-robin arbiter feeding the uart_tx byte channel.
// Revision : 1.0
// ============================================================================
module uart_tx_arbiter
  import uart_alu_pkg::*;
#(
  parameter int NUM_SRC    = 2,
  parameter int DATA_WIDTH = 8,
  parameter int TIMEOUT    = 1024
) (
  input  wire logic         clk,
  input  wire logic         rst_n,
  uart_tx_arbiter_if.slave  bus,
  output logic [NUM_SRC-1:0] grant_o,
  output logic               busy_o,
  output logic               timeout_o
);

  localparam int PTR_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam int CNT_W = cnt_width(TIMEOUT);
  localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [PTR_W-1:0] c_PTR_LAST = PTR_W'(NUM_SRC - 1);

  arb_state_e            r_state;
  logic [PTR_W-1:0]      r_ptr;
  logic [PTR_W-1:0]      r_owner;
  logic [NUM_SRC-1:0]    r_grant;
  logic [CNT_W-1:0]      r_cnt;
  logic                  r_timeout;
  logic [DATA_WIDTH-1:0] r_m_tdata;
  logic                  r_m_tvalid;
  logic                  r_m_tlast;

  logic [NUM_SRC-1:0]    w_pick;
  logic                  w_any;
  logic [PTR_W-1:0]      w_pick_idx;
  logic [DATA_WIDTH-1:0] w_owner_data;
  logic [NUM_SRC-1:0]    w_s_tready;
  logic                  w_out_free;
  logic                  w_accept;
  logic                  w_owner_valid;
  logic                  w_owner_last;
  logic                  w_expire;
  logic [PTR_W-1:0]      w_ptr_next;

  rr_priority_pick #(
    .NUM_SRC (NUM_SRC),
    .PTR_W   (PTR_W)
  ) u_pick (
    .req   (bus.s_tvalid),
    .ptr   (r_ptr),
    .grant (w_pick),
    .any   (w_any)
  );

  always_comb begin
    w_pick_idx   = '0;
    w_owner_data = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (w_pick[i]) w_pick_idx = PTR_W'(i);
      if (r_grant[i]) w_owner_data = w_owner_data | bus.s_tdata[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign w_out_free    = !r_m_tvalid || bus.m_tready;
  assign w_s_tready    = (r_state == LOCKED && w_out_free) ? r_grant : '0;
  assign w_accept      = |(w_s_tready & bus.s_tvalid);
  assign w_owner_valid = |(r_grant & bus.s_tvalid);
  assign w_owner_last  = |(r_grant & bus.s_tlast);
  // Only starvation counts; a stalled-but-valid owner is never expired.
  assign w_expire      = (TIMEOUT != 0) && (r_state == LOCKED) && !w_owner_valid
                         && (r_cnt == c_CNT_LAST);
  assign w_ptr_next    = (r_owner == c_PTR_LAST) ? '0 : r_owner + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_ptr     <= '0;
      r_owner   <= '0;
      r_grant   <= '0;
      r_cnt     <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_timeout <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_state <= LOCKED;
            r_grant <= w_pick;
            r_owner <= w_pick_idx;
            r_cnt   <= '0;
          end
        end
        LOCKED: begin
          if ((w_accept && w_owner_last) || w_expire) begin
            r_state   <= IDLE;
            r_grant   <= '0;
            r_ptr     <= w_ptr_next;
            r_cnt     <= '0;
            r_timeout <= w_expire;
          end else if (w_accept) begin
            r_cnt <= '0;
          end else if (!w_owner_valid) begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Output register drains on its own, whatever the FSM state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_m_tdata  <= '0;
      r_m_tvalid <= 1'b0;
      r_m_tlast  <= 1'b0;
    end else if (w_accept) begin
      r_m_tdata  <= w_owner_data;
      r_m_tlast  <= w_owner_last;
      r_m_tvalid <= 1'b1;
    end else if (bus.m_tready) begin
      r_m_tvalid <= 1'b0;
    end
  end

  assign bus.s_tready = w_s_tready;
  assign bus.m_tdata  = r_m_tdata;
  assign bus.m_tvalid = r_m_tvalid;
  assign bus.m_tlast  = r_m_tlast;
  assign grant_o      = r_grant;
  assign busy_o       = (r_state == LOCKED);
  assign timeout_o    = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_uart_tx_arbiter
// Brief    : Directed self-checking bench for uart_tx_arbiter (TIMEOUT=8).
// Revision : 1.0
// ============================================================================
module tb_uart_tx_arbiter;

  localparam int NUM_SRC = 2;
  localparam int DW      = 8;
  localparam int TMO     = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] grant;
  logic       busy;
  logic       tmo;
  int         n_total = 0;
  int         n_bad = 0;

  uart_tx_arbiter_if #(.NUM_SRC(NUM_SRC), .DATA_WIDTH(DW)) bus ();

  uart_tx_arbiter #(
    .NUM_SRC    (NUM_SRC),
    .DATA_WIDTH (DW),
    .TIMEOUT    (TMO)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .grant_o   (grant),
    .busy_o    (busy),
    .timeout_o (tmo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic drive(input int src, input logic v, input logic [7:0] d, input logic l);
    bus.s_tvalid[src]          = v;
    bus.s_tdata[src*DW +: DW]  = d;
    bus.s_tlast[src]           = l;
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [7:0] d, input logic l);
    check({tag, "_mvalid"}, bus.m_tvalid, v);
    if (v) begin
      check({tag, "_mdata"}, bus.m_tdata, d);
      check({tag, "_mlast"}, bus.m_tlast, l);
    end
  endtask

  task automatic chk_ctl(input string tag, input logic [1:0] g, input logic b, input logic [1:0] r);
    check({tag, "_grant"}, grant, g);
    check({tag, "_busy"}, busy, b);
    check({tag, "_sready"}, bus.s_tready, r);
  endtask

  initial begin
    #200000;
    $display("FAIL sim_limit: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    bus.s_tvalid = '0;
    bus.s_tdata  = '0;
    bus.s_tlast  = '0;
    bus.m_tready = 1'b1;
    #2;
    chk_out("rst", 1'b0, 8'h00, 1'b0);
    check("rst_mdata", bus.m_tdata, 0);
    check("rst_mlast", bus.m_tlast, 0);
    check("rst_tmo", tmo, 0);
    chk_ctl("rst", 2'b00, 1'b0, 2'b00);
    tick(); tick();
    rst_n = 1'b1;

    // Single source, three bytes
    drive(0, 1'b1, 8'h11, 1'b0);
    mid(); chk_ctl("t1_idle", 2'b00, 1'b0, 2'b00); tick();
    mid(); chk_ctl("t1_gnt", 2'b01, 1'b1, 2'b01); tick(); drive(0, 1'b1, 8'h22, 1'b0);
    mid(); chk_out("t1_b0", 1'b1, 8'h11, 1'b0); check("t1_b0_sready", bus.s_tready, 2'b01);
    tick(); drive(0, 1'b1, 8'h33, 1'b1);
    mid(); chk_out("t1_b1", 1'b1, 8'h22, 1'b0); tick(); drive(0, 1'b0, 8'h00, 1'b0);
    mid(); chk_out("t1_b2", 1'b1, 8'h33, 1'b1); chk_ctl("t1_rel", 2'b00, 1'b0, 2'b00); tick();
    mid(); check("t1_drain", bus.m_tvalid, 0);
    tick();

    rst_n = 1'b0; tick(); rst_n = 1'b1;

    // Simultaneous requests after reset, then round-robin return
    drive(0, 1'b1, 8'hA1, 1'b0); drive(1, 1'b1, 8'hB1, 1'b0);
    mid(); chk_ctl("t2_idle", 2'b00, 1'b0, 2'b00); tick();
    mid(); chk_ctl("t2_gA", 2'b01, 1'b1, 2'b01); tick(); drive(0, 1'b1, 8'hA2, 1'b1);
    mid(); chk_out("t2_A1", 1'b1, 8'hA1, 1'b0); tick(); drive(0, 1'b1, 8'hC1, 1'b1);
    mid(); chk_out("t2_A2", 1'b1, 8'hA2, 1'b1); chk_ctl("t2_gap1", 2'b00, 1'b0, 2'b00); tick();
    mid(); chk_ctl("t2_gB", 2'b10, 1'b1, 2'b10); check("t2_gB_mvalid", bus.m_tvalid, 0);
    tick(); drive(1, 1'b1, 8'hB2, 1'b1);
    mid(); chk_out("t2_B1", 1'b1, 8'hB1, 1'b0); check("t2_B1_sready", bus.s_tready, 2'b10);
    tick(); drive(1, 1'b0, 8'h00, 1'b0);
    mid(); chk_out("t2_B2", 1'b1, 8'hB2, 1'b1); chk_ctl("t2_gap2", 2'b00, 1'b0, 2'b00); tick();
    mid(); chk_ctl("t2_gC", 2'b01, 1'b1, 2'b01); tick(); drive(0, 1'b0, 8'h00, 1'b0);
    mid(); chk_out("t2_C1", 1'b1, 8'hC1, 1'b1); chk_ctl("t2_rel", 2'b00, 1'b0, 2'b00); tick();

    // Request from src1 in the middle of a src0 packet
    drive(0, 1'b1, 8'hD0, 1'b0); tick();
    mid(); chk_ctl("t3_gD", 2'b01, 1'b1, 2'b01); tick();
    drive(0, 1'b1, 8'hD1, 1'b0); drive(1, 1'b1, 8'hE0, 1'b1);
    mid(); check("t3_hold1", bus.s_tready, 2'b01); chk_out("t3_D0", 1'b1, 8'hD0, 1'b0);
    tick(); drive(0, 1'b1, 8'hD2, 1'b0);
    mid(); check("t3_hold2", bus.s_tready, 2'b01); chk_out("t3_D1", 1'b1, 8'hD1, 1'b0);
    tick(); drive(0, 1'b1, 8'hD3, 1'b1);
    mid(); check("t3_hold3", bus.s_tready, 2'b01); chk_out("t3_D2", 1'b1, 8'hD2, 1'b0);
    tick(); drive(0, 1'b0, 8'h00, 1'b0);
    mid(); chk_out("t3_D3", 1'b1, 8'hD3, 1'b1); chk_ctl("t3_gap", 2'b00, 1'b0, 2'b00); tick();
    mid(); chk_ctl("t3_gE", 2'b10, 1'b1, 2'b10); check("t3_gE_mvalid", bus.m_tvalid, 0);
    tick(); drive(1, 1'b0, 8'h00, 1'b0);
    mid(); chk_out("t3_E0", 1'b1, 8'hE0, 1'b1); tick();

    // Backpressure longer than TIMEOUT must not trip the watchdog
    drive(0, 1'b1, 8'hF0, 1'b0); tick();
    mid(); chk_ctl("t4_gF", 2'b01, 1'b1, 2'b01); tick();
    drive(0, 1'b1, 8'hF1, 1'b0); bus.m_tready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      mid();
      chk_out("t4_bp", 1'b1, 8'hF0, 1'b0);
      check("t4_bp_sready", bus.s_tready, 2'b00);
      check("t4_bp_tmo", tmo, 0);
      check("t4_bp_busy", busy, 1);
      tick();
    end
    bus.m_tready = 1'b1;
    mid(); check("t4_resume_sready", bus.s_tready, 2'b01); tick(); drive(0, 1'b1, 8'hF2, 1'b1);
    mid(); chk_out("t4_F1", 1'b1, 8'hF1, 1'b0); tick(); drive(0, 1'b0, 8'h00, 1'b0);
    mid(); chk_out("t4_F2", 1'b1, 8'hF2, 1'b1); chk_ctl("t4_rel", 2'b00, 1'b0, 2'b00);
    check("t4_rel_tmo", tmo, 0); tick();

    // Watchdog: src0 stalls after one byte while src1 waits
    drive(0, 1'b1, 8'h5A, 1'b0); tick();
    mid(); chk_ctl("t5_gG", 2'b01, 1'b1, 2'b01); tick();
    drive(0, 1'b0, 8'h00, 1'b0); drive(1, 1'b1, 8'h6B, 1'b1); bus.m_tready = 1'b0;
    for (int i = 0; i < TMO; i++) begin
      mid();
      check("t5_starve_tmo", tmo, 0);
      check("t5_starve_grant", grant, 2'b01);
      chk_out("t5_starve", 1'b1, 8'h5A, 1'b0);
      tick();
    end
    mid(); check("t5_tmo", tmo, 1); chk_ctl("t5_rel", 2'b00, 1'b0, 2'b00);
    chk_out("t5_held", 1'b1, 8'h5A, 1'b0); tick();
    mid(); check("t5_tmo_pulse", tmo, 0); chk_ctl("t5_gH", 2'b10, 1'b1, 2'b00); tick();
    bus.m_tready = 1'b1;
    mid(); check("t5_H_sready", bus.s_tready, 2'b10); chk_out("t5_G0", 1'b1, 8'h5A, 1'b0);
    tick(); drive(1, 1'b0, 8'h00, 1'b0);
    mid(); chk_out("t5_H0", 1'b1, 8'h6B, 1'b1); chk_ctl("t5_relH", 2'b00, 1'b0, 2'b00); tick();

    // Reset while a byte sits in the output register
    drive(0, 1'b1, 8'h71, 1'b0); tick();
    mid(); chk_ctl("t6_gJ", 2'b01, 1'b1, 2'b01); tick(); drive(0, 1'b1, 8'h72, 1'b1);
    mid(); chk_out("t6_J0", 1'b1, 8'h71, 1'b0);
    #1 rst_n = 1'b0;
    #1;
    check("t6_rst_mvalid", bus.m_tvalid, 0);
    check("t6_rst_mdata", bus.m_tdata, 0);
    check("t6_rst_mlast", bus.m_tlast, 0);
    check("t6_rst_tmo", tmo, 0);
    chk_ctl("t6_rst", 2'b00, 1'b0, 2'b00);
    drive(0, 1'b0, 8'h00, 1'b0);
    tick(); rst_n = 1'b1;
    drive(0, 1'b1, 8'h81, 1'b0);
    mid(); check("t6_post_busy", busy, 0); tick();
    mid(); chk_ctl("t6_gK", 2'b01, 1'b1, 2'b01); tick(); drive(0, 1'b1, 8'h82, 1'b1);
    mid(); chk_out("t6_K0", 1'b1, 8'h81, 1'b0); tick(); drive(0, 1'b0, 8'h00, 1'b0);
    mid(); chk_out("t6_K1", 1'b1, 8'h82, 1'b1); chk_ctl("t6_rel", 2'b00, 1'b0, 2'b00); tick();
    mid(); check("t6_drain", bus.m_tvalid, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
